// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between an initiator and the SRAM responder.
// The master modport is the initiator's view; the slave modport is the responder's view.
interface axi_lite_sram_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rresp;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite SRAM responder with independent, fixed-latency read and write channels.
// All outputs come straight from state registers; memory contents survive reset.
module axi_lite_sram_slave #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 1024,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int unsigned        RD_LAT    = 2,
    parameter int unsigned        WR_LAT    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi_lite_sram_slave_if.slave   bus
);
    localparam int unsigned    STRB_W = DATA_W / 8;
    localparam int unsigned    OFF_W  = $clog2(STRB_W);
    localparam int unsigned    IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(DEPTH * STRB_W);
    localparam logic [1:0]     RespOkay   = 2'b00;
    localparam logic [1:0]     RespSlvErr = 2'b10;

    typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Extra top bit keeps the span comparison free of wrap-around.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> OFF_W;
        return IDX_W'(off);
    endfunction

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic [3:0]        r_cnt_q, r_cnt_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              r_sample;
    logic [ADDR_W-1:0] r_sample_addr;

    always_comb begin
        r_state_d     = r_state_q;
        r_cnt_d       = r_cnt_q;
        r_addr_d      = r_addr_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        r_sample      = 1'b0;
        r_sample_addr = r_addr_q;
        case (r_state_q)
            RIdle: begin
                if (bus.arvalid) begin
                    r_addr_d = bus.araddr;
                    r_cnt_d  = 4'(RD_LAT);
                    if (RD_LAT == 0) begin
                        r_state_d     = RResp;
                        r_sample      = 1'b1;
                        r_sample_addr = bus.araddr;
                    end else begin
                        r_state_d = RWait;
                    end
                end
            end
            RWait: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    r_state_d = RResp;
                    r_sample  = 1'b1;
                end
            end
            RResp: begin
                if (bus.rready) r_state_d = RIdle;
            end
            default: r_state_d = RIdle;
        endcase
        if (r_sample) begin
            if (addr_in_range(r_sample_addr)) begin
                rdata_d = mem_q[addr_idx(r_sample_addr)];
                rresp_d = RespOkay;
            end else begin
                rdata_d = '0;
                rresp_d = RespSlvErr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= RIdle;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.arready = (r_state_q == RIdle);
    assign bus.rvalid  = (r_state_q == RResp);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic [3:0]        w_cnt_q, w_cnt_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              awready, wready, aw_hs, w_hs;
    logic              w_commit, w_commit_ok;

    assign awready = (w_state_q == WIdle) && !aw_done_q;
    assign wready  = (w_state_q == WIdle) && !w_done_q;
    assign aw_hs   = bus.awvalid && awready;
    assign w_hs    = bus.wvalid && wready;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = aw_hs ? bus.awaddr : awaddr_q;
        wdata_d   = w_hs ? bus.wdata : wdata_q;
        wstrb_d   = w_hs ? bus.wstrb : wstrb_q;
        bresp_d   = bresp_q;
        w_commit  = 1'b0;
        case (w_state_q)
            WIdle: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_cnt_d   = 4'(WR_LAT);
                    if (WR_LAT == 0) begin
                        w_state_d = WResp;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = WWait;
                    end
                end
            end
            WWait: begin
                w_cnt_d = w_cnt_q - 4'd1;
                if (w_cnt_q == 4'd1) begin
                    w_state_d = WResp;
                    w_commit  = 1'b1;
                end
            end
            WResp: begin
                if (bus.bready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
        w_commit_ok = addr_in_range(awaddr_d);
        if (w_commit) bresp_d = w_commit_ok ? RespOkay : RespSlvErr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= WIdle;
            w_cnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // No reset on the array; a same-edge read sample sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_commit_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_d[i]) mem_q[addr_idx(awaddr_d)][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = (w_state_q == WResp);
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave with default parameters (RD_LAT = WR_LAT = 2).
module tb_axi_lite_sram_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    axi_lite_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000),
        .RD_LAT(2), .WR_LAT(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // AW and W presented together; lat = cycles after the handshake cycle until bvalid.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic [1:0] resp);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
        bus.bready  = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = 0;
        while (bus.bvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d,
                           output logic [1:0] resp);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        lat = 0;
        while (bus.rvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        d    = bus.rdata;
        resp = bus.rresp;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic [31:0] held;
        logic [1:0]  resp;
        logic        seen;

        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;

        // 1. reset state
        repeat (3) tick();
        check("rst_awready", 32'(bus.awready), 1);
        check("rst_wready",  32'(bus.wready),  1);
        check("rst_arready", 32'(bus.arready), 1);
        check("rst_bvalid",  32'(bus.bvalid),  0);
        check("rst_rvalid",  32'(bus.rvalid),  0);
        check("rst_rdata",   bus.rdata,        0);
        rst_n = 1'b1;
        tick();

        // 2. basic write then read
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, resp);
        check("wr_latency", 32'(lat), 2);
        check("wr_bresp",   32'(resp), 0);
        check("wr_ready_back", {30'd0, bus.awready, bus.wready}, 32'h3);
        do_read(32'h8000_0010, lat, d, resp);
        check("rd_latency", 32'(lat), 2);
        check("rd_data",    d, 32'hDEAD_BEEF);
        check("rd_rresp",   32'(resp), 0);

        // 3. byte strobes
        do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, lat, resp);
        do_read(32'h8000_0012, lat, d, resp);
        check("strb_data", d, 32'hDE22_BE44);

        // 4. W three cycles ahead of AW
        seen = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.bready = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("w_first_wready",  32'(bus.wready),  0);
        check("w_first_awready", 32'(bus.awready), 1);
        repeat (2) begin
            if (bus.bvalid === 1'b1) seen = 1'b1;
            tick();
        end
        bus.awvalid = 1'b1; bus.awaddr = 32'h8000_0020;
        tick();
        bus.awvalid = 1'b0;
        if (bus.bvalid === 1'b1) seen = 1'b1;
        check("w_first_no_early_b", 32'(seen), 0);
        lat = 0;
        while (bus.bvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        check("w_first_latency", 32'(lat), 2);
        tick();
        bus.bready = 1'b0;
        check("w_first_single_b", 32'(bus.bvalid), 0);
        do_read(32'h8000_0020, lat, d, resp);
        check("w_first_data", d, 32'hCAFE_F00D);

        // 5. out of range
        do_read(32'h7FFF_FFFC, lat, d, resp);
        check("oor_rresp", 32'(resp), 2);
        check("oor_rdata", d, 0);
        do_write(32'h8000_0000, 32'hA5A5_A5A5, 4'hF, lat, resp);
        do_write(32'h8000_1000, 32'h1234_5678, 4'hF, lat, resp);
        check("oor_bresp", 32'(resp), 2);
        do_read(32'h8000_0000, lat, d, resp);
        check("oor_no_alias_write", d, 32'hA5A5_A5A5);
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, lat, resp);
        check("strb0_bresp", 32'(resp), 0);
        do_read(32'h8000_0010, lat, d, resp);
        check("strb0_data", d, 32'hDE22_BE44);

        // concurrent read sample and write commit on one word
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0020; bus.rready = 1'b1;
        bus.awvalid = 1'b1; bus.awaddr = 32'h8000_0020; bus.bready = 1'b1;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h0BAD_CAFE; bus.wstrb  = 4'hF;
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = 0;
        while (!(bus.rvalid === 1'b1 && bus.bvalid === 1'b1) && lat < 50) begin tick(); lat++; end
        check("conc_latency", 32'(lat), 2);
        check("conc_old_data", bus.rdata, 32'hCAFE_F00D);
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(32'h8000_0020, lat, d, resp);
        check("conc_new_data", d, 32'h0BAD_CAFE);

        // 6. read backpressure
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0010; bus.rready = 1'b0;
        tick();
        bus.arvalid = 1'b0;
        lat = 0;
        while (bus.rvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        check("bp_latency", 32'(lat), 2);
        held = bus.rdata;
        check("bp_first_data", held, 32'hDE22_BE44);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rvalid_held", 32'(bus.rvalid), 1);
            check("bp_rdata_held",  bus.rdata, held);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("bp_rvalid_drop", 32'(bus.rvalid), 0);
        check("bp_arready_back", 32'(bus.arready), 1);

        // reset while the read is waiting
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0010; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("mid_rst_arready_low", 32'(bus.arready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_arready_async", 32'(bus.arready), 1);
        seen = 1'b0;
        repeat (2) begin
            if (bus.rvalid === 1'b1) seen = 1'b1;
            tick();
        end
        rst_n = 1'b1;
        repeat (6) begin
            if (bus.rvalid === 1'b1) seen = 1'b1;
            tick();
        end
        bus.rready = 1'b0;
        check("mid_rst_no_rvalid", 32'(seen), 0);
        check("mid_rst_arready", 32'(bus.arready), 1);
        do_read(32'h8000_0010, lat, d, resp);
        check("mem_survives_rst", d, 32'hDE22_BE44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
